// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO execute-stage unit.
// Owns the HI/LO registers and performs MULT/MULTU (single cycle), DIV/DIVU
// (iterative restoring radix-2, one quotient bit per cycle), MTHI/MTLO
// writes and MFHI/MFLO reads.
//
// Ports:
//   clk, resetn   - rising-edge clock, asynchronous active-low reset
//   alucontrolE   - 8-bit ALU control code of the instruction in EX
//   srcaE, srcbE  - rs / rt operands
//   flushE        - EX instruction cancelled
//   stallE        - external hold on EX
//   div_stall     - combinational IF..EX hold while a divide is in flight
//   hilo_rdata    - HI for MFHI, LO otherwise (pre-write register values)
//   hi_o, lo_o    - current HI / LO registers
//
// Build option: define DIV_EARLY_OUT_EN to finish trivial divides
// (zero divisor, or |dividend| < |divisor|) in the accept cycle.

module hilo_muldiv_unit #(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  alucontrolE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        flushE,
    input  logic        stallE,
    output logic        div_stall,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // ALU control codes of the HI/LO class
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    localparam int unsigned CNT_W = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;

    // Divider datapath
    logic [31:0]        div_r;      // partial remainder
    logic [31:0]        div_q;      // dividend shifting out / quotient shifting in
    logic [31:0]        div_b;      // divisor magnitude
    logic               div_qneg;
    logic               div_rneg;
    logic [CNT_W-1:0]   div_cnt;

    logic               is_div;
    logic               op_signed;
    logic               accept;
    logic               commit;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [32:0]        rem_sh;
    logic               rem_ge;
    logic [31:0]        r_nxt;
    logic [31:0]        q_nxt;
    logic [31:0]        hi_fin;
    logic [31:0]        lo_fin;
    logic               cnt_last;

    // Control qualifiers
    assign is_div    = (alucontrolE == OP_DIV) || (alucontrolE == OP_DIVU);
    assign op_signed = (alucontrolE == OP_DIV);
    assign accept    = (state == S_IDLE) && is_div && !flushE;
    // A flush in RUN aborts the divide and releases the pipeline the same cycle
    assign div_stall = accept || ((state == S_RUN) && !flushE);
    assign commit    = !flushE && !stallE && !div_stall;

    // Operand magnitudes for the divider
    assign a_mag = (op_signed && srcaE[31]) ? (32'd0 - srcaE) : srcaE;
    assign b_mag = (op_signed && srcbE[31]) ? (32'd0 - srcbE) : srcbE;

    // Sign-extended / zero-extended 64-bit products (low 64 bits are exact)
    assign prod_s = {{32{srcaE[31]}}, srcaE} * {{32{srcbE[31]}}, srcbE};
    assign prod_u = {32'd0, srcaE} * {32'd0, srcbE};

    // One restoring shift/subtract step
    assign rem_sh = {div_r, div_q[31]};
    assign rem_ge = (rem_sh >= {1'b0, div_b});
    assign r_nxt  = rem_ge ? 32'(rem_sh - {1'b0, div_b}) : rem_sh[31:0];
    assign q_nxt  = {div_q[30:0], rem_ge};

    // Final sign correction; a zero divisor leaves the dividend in the
    // remainder, so re-applying the dividend sign restores the raw srcaE
    assign hi_fin   = div_rneg ? (32'd0 - r_nxt) : r_nxt;
    assign lo_fin   = (div_b == 32'd0) ? 32'hFFFF_FFFF
                    : (div_qneg ? (32'd0 - q_nxt) : q_nxt);
    assign cnt_last = (div_cnt == CNT_W'(DIV_ITER - 1));

`ifdef DIV_EARLY_OUT_EN
    logic early_out;
    assign early_out = (b_mag == 32'd0) || (a_mag < b_mag);
`endif

    // Read port and register views
    assign hilo_rdata = (alucontrolE == OP_MFHI) ? hi_r : lo_r;
    assign hi_o       = hi_r;
    assign lo_o       = lo_r;

    // FSM, HI/LO registers and divider datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            div_r    <= 32'd0;
            div_q    <= 32'd0;
            div_b    <= 32'd0;
            div_qneg <= 1'b0;
            div_rneg <= 1'b0;
            div_cnt  <= '0;
        end else begin
            // Single-cycle HI/LO writers; never coincide with a divide write
            // because commit is low whenever the divider owns the cycle
            if (commit) begin
                case (alucontrolE)
                    OP_MULT:  {hi_r, lo_r} <= prod_s;
                    OP_MULTU: {hi_r, lo_r} <= prod_u;
                    OP_MTHI:  hi_r <= srcaE;
                    OP_MTLO:  lo_r <= srcaE;
                    default:  ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_r    <= 32'd0;
                        div_q    <= a_mag;
                        div_b    <= b_mag;
                        div_qneg <= op_signed && (srcaE[31] ^ srcbE[31]);
                        div_rneg <= op_signed && srcaE[31];
                        div_cnt  <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (early_out) begin
                            hi_r  <= srcaE;
                            lo_r  <= (b_mag == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
`else
                        state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (flushE) begin
                        state <= S_IDLE;
                    end else begin
                        div_r   <= r_nxt;
                        div_q   <= q_nxt;
                        div_cnt <= div_cnt + CNT_W'(1);
                        if (cnt_last) begin
                            hi_r  <= hi_fin;
                            lo_r  <= lo_fin;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Held in DONE while EX is stalled so the divide never restarts
                    if (!stallE) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus a randomized
// instruction stream compared against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;
    localparam int         DIV_ITER = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  alucontrolE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        stallE;
    logic        div_stall;
    logic [31:0] hilo_rdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    hilo_muldiv_unit #(.DIV_ITER(DIV_ITER)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .alucontrolE(alucontrolE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .flushE     (flushE),
        .stallE     (stallE),
        .div_stall  (div_stall),
        .hilo_rdata (hilo_rdata),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input logic st);
        alucontrolE = op;
        srcaE       = a;
        srcbE       = b;
        flushE      = fl;
        stallE      = st;
    endtask

    // Reference divide: truncating division with the documented corner cases
    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    function automatic int exp_stall(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint am;
        longint bm;
        logic   early;
        logic   early_en;
        am    = sgn ? longint'($signed(a)) : longint'(a);
        bm    = sgn ? longint'($signed(b)) : longint'(b);
        am    = (am < 0) ? -am : am;
        bm    = (bm < 0) ? -bm : bm;
        early = (bm == 0) || (am < bm);
`ifdef DIV_EARLY_OUT_EN
        early_en = 1'b1;
`else
        early_en = 1'b0;
`endif
        return (early_en && early) ? 1 : 1 + DIV_ITER;
    endfunction

    // One non-dividing cycle (or a cancelled divide): check read port, then state
    task automatic single_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic fl, input logic st);
        drive(op, a, b, fl, st);
        @(negedge clk);
        check("single.stall", 32'(div_stall), 32'd0);
        check("single.rdata", hilo_rdata, (op == OP_MFHI) ? ref_hi : ref_lo);
        if (!fl && !st) begin
            case (op)
                OP_MULT:  {ref_hi, ref_lo} = 64'(longint'($signed(a)) * longint'($signed(b)));
                OP_MULTU: {ref_hi, ref_lo} = 64'(a) * 64'(b);
                OP_MTHI:  ref_hi = a;
                OP_MTLO:  ref_lo = a;
                default:  ;
            endcase
        end
        next_edge();
        check("single.hi", hi_o, ref_hi);
        check("single.lo", lo_o, ref_lo);
    endtask

    // Issue a divide and follow it to its DONE cycle; returns at that cycle's negedge
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int          cnt;
        logic [31:0] q;
        logic [31:0] r;
        drive(op, a, b, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!div_stall) break;
            cnt++;
            next_edge();
        end
        ref_div(op == OP_DIV, a, b, q, r);
        ref_lo = q;
        ref_hi = r;
        check("div.stall_cycles", 32'(cnt), 32'(exp_stall(op == OP_DIV, a, b)));
        check("div.lo", lo_o, ref_lo);
        check("div.hi", hi_o, ref_hi);
    endtask

    initial begin
        logic [7:0]  ops [9];
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        fl;
        logic        st;

        ops = '{OP_NOP, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        resetn = 1'b0;
        drive(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.hi", hi_o, 32'd0);
        check("reset.lo", lo_o, 32'd0);
        check("reset.stall", 32'(div_stall), 32'd0);
        resetn = 1'b1;
        next_edge();

        // Multiplies
        single_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("mult.hi", hi_o, 32'hFFFF_FFFF);
        check("mult.lo", lo_o, 32'hFFFF_FFFE);
        single_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("multu.hi", hi_o, 32'h0000_0001);
        check("multu.lo", lo_o, 32'hFFFF_FFFE);

        // Back-to-back divides: the second is accepted right after DONE
        run_div(OP_DIVU, 32'd100, 32'd7);
        check("divu.lo", lo_o, 32'h0000_000E);
        check("divu.hi", hi_o, 32'h0000_0002);
        next_edge();
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg.lo", lo_o, 32'hFFFF_FFFD);
        check("div_neg.hi", hi_o, 32'hFFFF_FFFF);
        next_edge();
        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf.lo", lo_o, 32'h8000_0000);
        check("div_ovf.hi", hi_o, 32'h0000_0000);
        next_edge();
        run_div(OP_DIV, 32'd5, 32'd0);
        check("div0.lo", lo_o, 32'hFFFF_FFFF);
        check("div0.hi", hi_o, 32'h0000_0005);
        next_edge();
        run_div(OP_DIVU, 32'hFFFF_FFFB, 32'd0);
        next_edge();
        drive(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        next_edge();

        // Abort a divide on run cycle 10
        drive(OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
        next_edge();
        repeat (9) next_edge();
        flushE = 1'b1;
        @(negedge clk);
        check("flush.stall_drop", 32'(div_stall), 32'd0);
        next_edge();
        drive(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("flush.idle_stall", 32'(div_stall), 32'd0);
        check("flush.hi_kept", hi_o, ref_hi);
        check("flush.lo_kept", lo_o, ref_lo);
        next_edge();
        run_div(OP_DIV, 32'd1000, 32'hFFFF_FFFD);
        next_edge();

        // MTHI / MFHI forwarding and flushed MTLO
        single_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("mfhi.rdata", hilo_rdata, 32'h1234_5678);
        next_edge();
        single_op(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        single_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b1);

        // Held in DONE by stallE: no rewrite, no restart
        run_div(OP_DIVU, 32'd77, 32'd5);
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_edge();
            @(negedge clk);
            check("done_hold.stall", 32'(div_stall), 32'd0);
            check("done_hold.hi", hi_o, ref_hi);
            check("done_hold.lo", lo_o, ref_lo);
        end
        stallE = 1'b0;
        next_edge();
        drive(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        next_edge();

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = ($urandom_range(0, 1) == 1) ? 32'd0 - 32'($urandom_range(1, 20))
                                                                       : 32'($urandom_range(1, 20)); end
                2: begin a = $urandom; b = 32'd0; end
                default: begin a = 32'($urandom_range(0, 50)); b = $urandom; end
            endcase
            fl = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 9) == 0);
            if ((op == OP_DIV || op == OP_DIVU) && !fl) begin
                run_div(op, a, b);
                next_edge();
                drive(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
                next_edge();
            end else begin
                single_op(op, a, b, fl, (op == OP_DIV || op == OP_DIVU) ? 1'b0 : st);
            end
        end

        // Reset in the middle of a divide
        drive(OP_DIV, 32'd12345, 32'd67, 1'b0, 1'b0);
        repeat (5) next_edge();
        drive(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        check("midreset.hi", hi_o, 32'd0);
        check("midreset.lo", lo_o, 32'd0);
        check("midreset.stall", 32'(div_stall), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        next_edge();
        run_div(OP_DIVU, 32'd100, 32'd7);
        next_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
